aes_block_loader: RTL and testbench

- Downstream consumer of the USB receiver's PID and data FIFOs.
- Pops one PID per packet and validates it as DATA0/DATA1, then packs the payload bytes into 128-bit blocks for the AES encryption core using a valid/ready handshake.
- Marks the final block of each packet and reports its valid byte count.
- Reports malformed or unexpected PIDs.

---
 rtl/aes_block_loader.sv | 120 ++++++++++++
 tb/tb_aes_block_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// aes_block_loader: pops a DATA0/DATA1 PID per packet and packs payload bytes into 128-bit AES blocks.
// The final block of each packet is flagged with blk_last and carries its valid byte count in blk_len.
module aes_block_loader #(
    parameter int BLK_BYTES = 16,
    parameter int END_CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     pid_empty,
    input  logic [7:0]               r_pid,
    output logic                     rpid_enable,
    input  logic                     data_empty,
    input  logic [7:0]               r_data,
    output logic                     rdata_enable,
    input  logic                     rcving,
    output logic [8*BLK_BYTES-1:0]   blk_data,
    output logic [4:0]               blk_len,
    output logic                     blk_last,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     pid_err,
    output logic                     pid_seq,
    output logic                     busy
);
    typedef enum logic [2:0] {IDLE, GET_PID, LOAD, FULL, EMIT} state_t;

    state_t               state;
    logic [4:0]           cnt;
    logic [END_CNT_W-1:0] end_cnt;
    logic                 rcving_q;
    logic                 fall;
    logic                 end_pending;
    logic                 pid_ok;
    logic                 pop;
    logic                 consume;

    assign fall         = rcving_q & ~rcving;
    assign end_pending  = end_cnt != '0;
    assign pid_ok       = r_pid == 8'hC3 || r_pid == 8'h4B;
    assign pop          = state == LOAD && !data_empty && cnt < 5'(BLK_BYTES);
    assign consume      = (state == GET_PID && !pid_ok) ||
                          ((state == LOAD || state == FULL) && data_empty && end_pending);
    assign rdata_enable = pop;
    assign rpid_enable  = state == GET_PID && !pid_empty;
    assign blk_valid    = state == EMIT;
    assign busy         = state != IDLE;

    // A fall and a consume in the same cycle cancel; the count saturates at both ends.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rcving_q <= 1'b0;
            end_cnt  <= '0;
        end else begin
            rcving_q <= rcving;
            if (fall && !consume && end_cnt != '1)
                end_cnt <= end_cnt + 1'b1;
            else if (!fall && consume && end_pending)
                end_cnt <= end_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            blk_data <= '0;
            blk_len  <= '0;
            blk_last <= 1'b0;
            pid_err  <= 1'b0;
            pid_seq  <= 1'b0;
        end else begin
            pid_err <= 1'b0;
            case (state)
                IDLE: if (!pid_empty) state <= GET_PID;
                GET_PID: begin
                    if (pid_ok) begin
                        pid_seq <= r_pid == 8'h4B;
                        state   <= LOAD;
                    end else begin
                        pid_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                LOAD: begin
                    if (pop) begin
                        // Lane 0 sits at the top of the block, so lane cnt starts at bit 8*(15-cnt).
                        blk_data[{~cnt[3:0], 3'b000} +: 8] <= r_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == 5'(BLK_BYTES - 1)) state <= FULL;
                    end else if (data_empty && end_pending) begin
                        if (cnt != '0) begin
                            blk_last <= 1'b1;
                            blk_len  <= cnt;
                            state    <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FULL: begin
                    if (!data_empty || end_pending) begin
                        blk_last <= data_empty;
                        blk_len  <= 5'(BLK_BYTES);
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        cnt      <= '0;
                        blk_data <= '0;
                        blk_len  <= '0;
                        blk_last <= 1'b0;
                        state    <= blk_last ? IDLE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: directed packets through modelled PID/data FIFOs with a block scoreboard.
module tb_aes_block_loader;
    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         pid_empty = 1'b1;
    logic [7:0]   r_pid = 8'h00;
    logic         rpid_enable;
    logic         data_empty = 1'b1;
    logic [7:0]   r_data = 8'h00;
    logic         rdata_enable;
    logic         rcving = 1'b0;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic         pid_err;
    logic         pid_seq;
    logic         busy;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   len;
        logic         last;
        logic         seq;
    } blk_t;

    logic [7:0] pq[$];
    logic [7:0] dq[$];
    blk_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         pops = 0;
    int         errs = 0;
    logic       pend_d = 1'b0;
    logic       pend_p = 1'b0;

    aes_block_loader dut (
        .clk(clk), .n_rst(n_rst), .pid_empty(pid_empty), .r_pid(r_pid),
        .rpid_enable(rpid_enable), .data_empty(data_empty), .r_data(r_data),
        .rdata_enable(rdata_enable), .rcving(rcving), .blk_data(blk_data),
        .blk_len(blk_len), .blk_last(blk_last), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .pid_err(pid_err), .pid_seq(pid_seq), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model and monitor: pops granted at the last rising edge retire here, heads refresh,
    // then outputs are sampled mid-low-phase where everything is settled.
    always @(negedge clk) begin
        if (pend_d && dq.size() > 0) begin
            void'(dq.pop_front());
            pops++;
        end
        if (pend_p && pq.size() > 0) void'(pq.pop_front());
        data_empty = dq.size() == 0;
        r_data     = data_empty ? 8'h00 : dq[0];
        pid_empty  = pq.size() == 0;
        r_pid      = pid_empty ? 8'h00 : pq[0];
        #1;
        pend_d = rdata_enable;
        pend_p = rpid_enable;
        if (pid_err) errs++;
        if (rdata_enable) begin
            total++;
            if (data_empty) begin bad++; $display("FAIL data_pop_when_empty: rdata_enable=1 data_empty=1"); end
        end
        if (rpid_enable) begin
            total++;
            if (pid_empty) begin bad++; $display("FAIL pid_pop_when_empty: rpid_enable=1 pid_empty=1"); end
        end
        if (blk_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_block: data=%h len=%0d last=%0d", blk_data, blk_len, blk_last);
            end else begin
                if (blk_data !== sb[0].data || blk_len !== sb[0].len || blk_last !== sb[0].last || pid_seq !== sb[0].seq) begin
                    bad++;
                    $display("FAIL block: got data=%h len=%0d last=%0d seq=%0d want data=%h len=%0d last=%0d seq=%0d",
                             blk_data, blk_len, blk_last, pid_seq, sb[0].data, sb[0].len, sb[0].last, sb[0].seq);
                end
                if (blk_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_blk(input logic [127:0] d, input logic [4:0] l, input logic last, input logic seq);
        blk_t b;
        b.data = d; b.len = l; b.last = last; b.seq = seq;
        sb.push_back(b);
    endtask

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) dq.push_back(base + 8'(i));
    endtask

    // One packet: rcving high for a cycle, then PID+payload land as rcving falls.
    task automatic send(input logic [7:0] pid, input logic [7:0] base, input int n);
        rcving = 1'b1;
        tick();
        pq.push_back(pid);
        push_bytes(base, n);
        rcving = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (pq.size() == 0 && dq.size() == 0 && sb.size() == 0 && !busy) return;
        end
        total++; bad++;
        $display("FAIL %s_timeout: busy=%0d pending_blocks=%0d want idle", name, busy, sb.size());
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (blk_valid) return;
        end
        total++; bad++;
        $display("FAIL %s_timeout: blk_valid=0 want 1", name);
    endtask

    initial begin
        int p0;
        int e0;
        repeat (3) tick();
        chk("reset_outputs", {blk_data, blk_len, blk_last, blk_valid, pid_err, pid_seq, busy, rpid_enable, rdata_enable}, '0);
        n_rst = 1'b0;
        tick();

        // reset in the middle of LOAD after 5 bytes
        rcving = 1'b1;
        tick();
        pq.push_back(8'hC3);
        push_bytes(8'hE0, 8);
        p0 = pops;
        for (int i = 0; i < 100 && pops - p0 < 5; i++) begin
            @(negedge clk);
            #2;
        end
        chk("pops_before_reset", 32'(pops - p0), 32'd5);
        n_rst = 1'b1;
        #1;
        chk("midload_reset", {blk_valid, busy, pid_err}, 3'b000);
        rcving = 1'b0;
        pq.delete();
        dq.delete();
        tick();
        n_rst = 1'b0;
        tick();
        expect_blk(128'h77780000_00000000_00000000_00000000, 5'd2, 1'b1, 1'b0);
        send(8'hC3, 8'h77, 2);
        wait_done("after_reset");

        // DATA0, exactly 16 bytes
        expect_blk(128'h00010203_04050607_08090a0b_0c0d0e0f, 5'd16, 1'b1, 1'b0);
        send(8'hC3, 8'h00, 16);
        wait_done("full16");

        // DATA1, 20 bytes, consumer stalls 10 cycles on the first block
        blk_ready = 1'b0;
        expect_blk(128'h20212223_24252627_28292a2b_2c2d2e2f, 5'd16, 1'b0, 1'b1);
        expect_blk(128'h30313233_00000000_00000000_00000000, 5'd4, 1'b1, 1'b1);
        send(8'h4B, 8'h20, 20);
        wait_valid("stall");
        repeat (10) tick();
        blk_ready = 1'b1;
        wait_done("bytes20");

        // IN token, then malformed PID
        p0 = pops;
        e0 = errs;
        send(8'h69, 8'h00, 0);
        wait_done("pid_in");
        send(8'hC5, 8'h00, 0);
        wait_done("pid_bad");
        repeat (2) tick();
        chk("pid_err_pulses", 32'(errs - e0), 32'd2);
        chk("reject_no_pops", 32'(pops - p0), 32'd0);
        chk("reject_end_cnt", 128'(dut.end_cnt), 128'd0);

        // zero-length DATA0 then 3-byte DATA1
        send(8'hC3, 8'h00, 0);
        wait_done("zero_len");
        chk("zero_len_end_cnt", 128'(dut.end_cnt), 128'd0);
        expect_blk(128'ha0a1a200_00000000_00000000_00000000, 5'd3, 1'b1, 1'b1);
        send(8'h4B, 8'hA0, 3);
        wait_done("len3");

        // two packet ends counted before either PID is seen
        blk_ready = 1'b0;
        rcving = 1'b1; tick();
        rcving = 1'b0; tick();
        rcving = 1'b1; tick();
        rcving = 1'b0; tick();
        tick();
        chk("two_ends_counted", 128'(dut.end_cnt), 128'd2);
        expect_blk(128'h50515253_54000000_00000000_00000000, 5'd5, 1'b1, 1'b0);
        expect_blk(128'h60616263_64656600_00000000_00000000, 5'd7, 1'b1, 1'b1);
        pq.push_back(8'hC3);
        pq.push_back(8'h4B);
        push_bytes(8'h50, 5);
        wait_valid("two_pkt");
        push_bytes(8'h60, 7);
        tick();
        blk_ready = 1'b1;
        wait_done("two_pkt");
        chk("final_end_cnt", 128'(dut.end_cnt), 128'd0);
        chk("total_pid_err", 32'(errs), 32'd2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
